stc_dwriteback: RTL and testbench



---
 rtl/stc_pkg.sv | 22 ++
 rtl/stc_fifo2.sv | 57 +++++
 rtl/stc_dwriteback.sv | 142 ++++++++++++++
 tb/tb_stc_dwriteback.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stc_pkg.sv
// Shared types for the D-buffer writeback stage: FSM states, row geometry and
// the FIFO entry layout (row data, byte address, last-row flag).
package stc_pkg;

   localparam int unsigned STC_DW_MEM    = 256;
   localparam int unsigned STC_DW_ADDR   = 32;
   localparam int unsigned STC_ROW_BYTES = STC_DW_MEM / 8;

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StFlush,
      StDone
   } stc_state_e;

   typedef struct packed {
      logic [STC_DW_MEM-1:0]  data;
      logic [STC_DW_ADDR-1:0] addr;
      logic                   last;
   } stc_entry_t;

endpackage

// File: rtl/stc_fifo2.sv
// Two-entry register FIFO. slot0 is always the head, so the read data is a
// plain register output and stays stable until popped.
module stc_fifo2 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] slot0_q, slot0_d;
   logic [W-1:0] slot1_q, slot1_d;
   logic [1:0]   count_q, count_d;
   logic         do_pop, do_push;

   // Next-state: apply the pop first, then place the push behind whatever remains.
   always_comb begin
      do_pop  = pop_i && (count_q != 2'd0);
      do_push = push_i && ((count_q != 2'd2) || do_pop);
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      if (do_pop) begin
         slot0_d = slot1_q;
         count_d = count_q - 2'd1;
      end
      if (do_push) begin
         if (count_d == 2'd0) begin
            slot0_d = wdata_i;
         end else begin
            slot1_d = wdata_i;
         end
         count_d = count_d + 2'd1;
      end
   end

   // Storage and occupancy registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assign rdata_o = slot0_q;
   assign count_o = count_q;

endmodule

// File: rtl/stc_dwriteback.sv
// Drain/writeback stage behind stc_Dbuffer: walks the column index, queues each
// row in a 2-entry FIFO and streams rows to memory over valid/ready with
// incrementing byte addresses.
// Optional feature: define STC_WB_RELU_EN to clamp negative signed elements to
// zero as rows enter the FIFO.
module stc_dwriteback
   import stc_pkg::*;
#(
   parameter int unsigned M       = 16,
   parameter int unsigned N       = 16,
   parameter int unsigned DW_DATA = 16,
   parameter int unsigned DW_COL  = 4,
   parameter int unsigned DW_MEM  = 256,
   parameter int unsigned DW_ADDR = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [DW_ADDR-1:0]     base_addr,
   output logic [DW_COL-1:0]      col,
   input  logic [N*DW_DATA-1:0]   D_row_out,
   output logic                   mem_valid,
   input  logic                   mem_ready,
   output logic [DW_ADDR-1:0]     mem_addr,
   output logic [DW_MEM-1:0]      mem_data,
   output logic                   mem_last,
   output logic                   busy,
   output logic                   done
);

   if (DW_MEM != N * DW_DATA) begin : g_bad_mem_width
      $error("stc_dwriteback: DW_MEM must equal N*DW_DATA");
   end
   if ((2 ** DW_COL) < M) begin : g_bad_col_width
      $error("stc_dwriteback: DW_COL too narrow for M columns");
   end
   // The FIFO entry layout is fixed by stc_pkg.
   if ((DW_MEM != STC_DW_MEM) || (DW_ADDR != STC_DW_ADDR)) begin : g_bad_entry_geom
      $error("stc_dwriteback: DW_MEM/DW_ADDR must match stc_pkg entry geometry");
   end

   localparam logic [DW_COL-1:0]  LastCol  = DW_COL'(M - 1);
   localparam logic [DW_ADDR-1:0] RowBytes = DW_ADDR'(STC_ROW_BYTES);

   stc_state_e         state_q, state_d;
   logic [DW_COL-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DW_ADDR-1:0] addr_q, addr_d;
   logic               push, pop;
   logic [1:0]         fifo_count;
   logic [DW_MEM-1:0]  row_data;
   stc_entry_t         wr_entry, rd_entry;

   // Row conditioning at push time (pass-through unless ReLU is built in).
   always_comb begin
      row_data = D_row_out;
`ifdef STC_WB_RELU_EN
      for (int j = 0; j < N; j++) begin
         if (D_row_out[j*DW_DATA + DW_DATA - 1]) begin
            row_data[j*DW_DATA +: DW_DATA] = '0;
         end
      end
`endif
   end

   // FSM next-state, column walk and address stepping.
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      addr_d   = addr_q;
      push     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StDrain;
               rd_ptr_d = '0;
               addr_d   = base_addr;
            end
         end
         StDrain: begin
            // A full FIFO stalls the walk; col holds at rd_ptr.
            if (fifo_count != 2'd2) begin
               push     = 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
               addr_d   = addr_q + RowBytes;
               if (rd_ptr_q == LastCol) begin
                  state_d = StFlush;
               end
            end
         end
         StFlush: begin
            if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM, column pointer and address registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         rd_ptr_q <= '0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         addr_q   <= addr_d;
      end
   end

   assign wr_entry.data = row_data;
   assign wr_entry.addr = addr_q;
   assign wr_entry.last = (rd_ptr_q == LastCol);

   stc_fifo2 #(
      .W($bits(stc_entry_t))
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (rd_entry),
      .count_o (fifo_count)
   );

   assign mem_valid = (fifo_count != 2'd0);
   assign pop       = mem_valid && mem_ready;
   assign mem_addr  = rd_entry.addr;
   assign mem_data  = rd_entry.data;
   assign mem_last  = rd_entry.last;
   assign col       = (state_q == StDrain) ? rd_ptr_q : '0;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);

endmodule

// File: tb/tb_stc_dwriteback.sv
// Scoreboard bench for stc_dwriteback: each accepted start pushes the expected
// beats; a negedge monitor pops and compares every accepted beat and checks
// that stalled beats are held stable.
module tb_stc_dwriteback;

   localparam int unsigned M       = 16;
   localparam int unsigned N       = 16;
   localparam int unsigned DW_DATA = 16;
   localparam int unsigned DW_COL  = 4;
   localparam int unsigned DW_MEM  = 256;
   localparam int unsigned DW_ADDR = 32;

`ifdef STC_WB_RELU_EN
   localparam logic [15:0] ExpNegElem = 16'h0000;
`else
   localparam logic [15:0] ExpNegElem = 16'hFFFF;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [DW_ADDR-1:0]   base_addr;
   logic [DW_COL-1:0]    col;
   logic [N*DW_DATA-1:0] D_row_out;
   logic                 mem_valid;
   logic                 mem_ready;
   logic [DW_ADDR-1:0]   mem_addr;
   logic [DW_MEM-1:0]    mem_data;
   logic                 mem_last;
   logic                 busy;
   logic                 done;

   logic [DW_MEM-1:0] rows [M];
   assign D_row_out = rows[col];

   typedef struct {
      logic [DW_MEM-1:0]  data;
      logic [DW_ADDR-1:0] addr;
      logic               last;
   } beat_t;

   beat_t sb[$];
   beat_t hold;
   beat_t exp_b;
   logic  hold_v = 1'b0;
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    done_cnt = 0;
   int    last_done_cyc = -1;
   int    beats = 0;

   stc_dwriteback #(
      .M(M), .N(N), .DW_DATA(DW_DATA), .DW_COL(DW_COL), .DW_MEM(DW_MEM), .DW_ADDR(DW_ADDR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .col       (col),
      .D_row_out (D_row_out),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_last  (mem_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [DW_MEM-1:0] act,
                      input logic [DW_MEM-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: row k lands at base + k*32 bytes; negative elements clamp when ReLU is on.
   function automatic logic [DW_MEM-1:0] xform(input logic [DW_MEM-1:0] r);
      logic [DW_MEM-1:0] o = r;
`ifdef STC_WB_RELU_EN
      for (int j = 0; j < N; j++) begin
         if ($signed(r[j*DW_DATA +: DW_DATA]) < 0) o[j*DW_DATA +: DW_DATA] = '0;
      end
`endif
      return o;
   endfunction

   task automatic expect_drain(input logic [DW_ADDR-1:0] base);
      beat_t b;
      for (int k = 0; k < M; k++) begin
         b.data = xform(rows[k]);
         b.addr = base + DW_ADDR'(k * (DW_MEM / 8));
         b.last = (k == M - 1);
         sb.push_back(b);
      end
   endtask

   // Monitor: compare accepted beats, and require stalled beats to be held.
   always @(negedge clk) begin
      if (reset) begin
         hold_v = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (hold_v) begin
            chk("hold_valid", DW_MEM'(mem_valid), DW_MEM'(1'b1));
            chk("hold_addr", DW_MEM'(mem_addr), DW_MEM'(hold.addr));
            chk("hold_data", mem_data, hold.data);
            chk("hold_last", DW_MEM'(mem_last), DW_MEM'(hold.last));
         end
         hold_v = 1'b0;
         if (mem_valid) begin
            if (mem_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat actual addr=%0h required=no beat", mem_addr);
               end else begin
                  exp_b = sb.pop_front();
                  chk("beat_addr", DW_MEM'(mem_addr), DW_MEM'(exp_b.addr));
                  chk("beat_data", mem_data, exp_b.data);
                  chk("beat_last", DW_MEM'(mem_last), DW_MEM'(exp_b.last));
               end
               beats++;
            end else begin
               hold_v    = 1'b1;
               hold.addr = mem_addr;
               hold.data = mem_data;
               hold.last = mem_last;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ready_for(input int mode, input int n);
      case (mode)
         0:       return 1'b1;
         1:       return ((n % 4) == 0) || ((n % 4) == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic start_drain(input logic [DW_ADDR-1:0] base);
      base_addr = base;
      start     = 1'b1;
      expect_drain(base);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int mode, input int budget);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < budget) begin
         mem_ready = ready_for(mode, n);
         tick();
         n++;
      end
      checks++;
      if (done_cnt == d0) begin
         failures++;
         $display("FAIL done_timeout actual=no done required=done within %0d cycles", budget);
      end
   endtask

   task automatic rand_rows();
      for (int k = 0; k < M; k++) rows[k] = {$urandom, $urandom, $urandom, $urandom,
                                             $urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      int t0;
      int d0;
      int n;
      int b0;
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      mem_ready = 1'b0;
      for (int k = 0; k < M; k++) rows[k] = '0;
      repeat (3) tick();

      // Reset state
      @(negedge clk);
      chk("rst_col", DW_MEM'(col), '0);
      chk("rst_mem_valid", DW_MEM'(mem_valid), '0);
      chk("rst_mem_addr", DW_MEM'(mem_addr), '0);
      chk("rst_mem_data", mem_data, '0);
      chk("rst_mem_last", DW_MEM'(mem_last), '0);
      chk("rst_busy", DW_MEM'(busy), '0);
      chk("rst_done", DW_MEM'(done), '0);
      tick();
      reset = 1'b0;
      tick();

      // Row k = all k+1, base 0x1000, ready held high: latency and beat ordering
      for (int k = 0; k < M; k++) rows[k] = {N{DW_DATA'(k + 1)}};
      mem_ready = 1'b1;
      base_addr = 32'h1000;
      start     = 1'b1;
      t0        = cyc;
      expect_drain(32'h1000);
      @(negedge clk);
      chk("busy_at_start", DW_MEM'(busy), '0);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("busy_t1", DW_MEM'(busy), DW_MEM'(1'b1));
      chk("col_t1", DW_MEM'(col), '0);
      wait_done(0, 100);
      chk("done_cycle", DW_MEM'(last_done_cyc), DW_MEM'(t0 + M + 2));
      chk("busy_after_done", DW_MEM'(busy), '0);
      chk("sb_empty_a", DW_MEM'(sb.size()), '0);

      // Ready pattern 1,0,0,1 with random rows
      rand_rows();
      mem_ready = 1'b1;
      start_drain(DW_ADDR'($urandom) & 32'hFFFF_FFE0);
      wait_done(1, 300);
      chk("sb_empty_b", DW_MEM'(sb.size()), '0);

      // Ready low 20 cycles: walk halts at col 2, row 0 held (includes ReLU row)
      rand_rows();
      rows[0][15:0]  = 16'hFFFF;
      rows[0][31:16] = 16'h0005;
      mem_ready = 1'b0;
      start_drain(32'h0000_3000);
      repeat (19) tick();
      @(negedge clk);
      chk("stall_col", DW_MEM'(col), DW_MEM'(2));
      chk("stall_valid", DW_MEM'(mem_valid), DW_MEM'(1'b1));
      chk("stall_addr", DW_MEM'(mem_addr), DW_MEM'(32'h0000_3000));
      chk("relu_neg_elem", DW_MEM'(mem_data[15:0]), DW_MEM'(ExpNegElem));
      chk("relu_pos_elem", DW_MEM'(mem_data[31:16]), DW_MEM'(16'h0005));
      wait_done(0, 100);
      chk("sb_empty_c", DW_MEM'(sb.size()), '0);

      // Reset after beat 5: abandon drain, no done, then a fresh drain from row 0
      rand_rows();
      mem_ready = 1'b1;
      b0 = beats;
      start_drain(32'h0000_5000);
      n = 0;
      while (beats < b0 + 5 && n < 100) begin
         tick();
         n++;
      end
      chk("reach_beat5", DW_MEM'(beats >= b0 + 5), DW_MEM'(1'b1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      d0 = done_cnt;
      @(negedge clk);
      chk("rst_mid_valid", DW_MEM'(mem_valid), '0);
      chk("rst_mid_busy", DW_MEM'(busy), '0);
      repeat (5) tick();
      chk("rst_mid_no_done", DW_MEM'(done_cnt), DW_MEM'(d0));
      start_drain(32'h0000_4000);
      wait_done(2, 400);
      chk("sb_empty_d", DW_MEM'(sb.size()), '0);

      // Address wrap and a second start mid-drain that must be ignored
      rand_rows();
      mem_ready = 1'b1;
      start_drain(32'hFFFF_FFE0);
      for (int i = 0; i < 6; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         tick();
      end
      base_addr = 32'h0000_2000;
      start     = 1'b1;
      tick();
      start = 1'b0;
      wait_done(2, 400);
      chk("sb_empty_f", DW_MEM'(sb.size()), '0);
      d0 = done_cnt;
      repeat (10) tick();
      chk("no_extra_done", DW_MEM'(done_cnt), DW_MEM'(d0));
      chk("idle_after_f", DW_MEM'(busy), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
